// File: rtl/sap_control_sequencer_if.sv
// Control bundle between the SAP sequencer and the datapath registers.
// The sequencer (master) reads the IR opcode nibble and drives the ring
// position, halt flag and every load/enable pin; the datapath is the slave.
interface sap_control_sequencer_if;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       hlt;
    logic       cp;
    logic       ep;
    logic       lm_n;
    logic       ce_n;
    logic       li_n;
    logic       ei_n;
    logic       la_n;
    logic       ea;
    logic       su;
    logic       eu;
    logic       lb_n;
    logic       lo_n;

    modport master (
        input  opcode,
        output t_state, hlt, cp, ep, lm_n, ce_n, li_n, ei_n,
               la_n, ea, su, eu, lb_n, lo_n
    );

    modport slave (
        output opcode,
        input  t_state, hlt, cp, ep, lm_n, ce_n, li_n, ei_n,
               la_n, ea, su, eu, lb_n, lo_n
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: six-phase ring counter plus a halt state, decoding
// the IR opcode nibble into the per-phase control word for the datapath.
//
//   state | meaning
//   T1    | PC -> bus, MAR load
//   T2    | PC increment
//   T3    | RAM -> bus, IR load
//   T4    | execute phase 1 (HLT leaves the ring here)
//   T5    | execute phase 2
//   T6    | execute phase 3, then back to T1
//   HALT  | stopped, clock gated externally; only clr leaves
module sap_control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic                          clk,
    input  logic                          clr,
    sap_control_sequencer_if.master       bus
);

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t state_q;

    // Ring advance; HLT is the only opcode that diverts sequencing (at T4).
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_T1;
        end else begin
            case (state_q)
                S_T1:    state_q <= S_T2;
                S_T2:    state_q <= S_T3;
                S_T3:    state_q <= S_T4;
                S_T4:    state_q <= (bus.opcode == OP_HLT) ? S_HALT : S_T5;
                S_T5:    state_q <= S_T6;
                S_T6:    state_q <= S_T1;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_T1;
            endcase
        end
    end

    // One-hot ring position and halt flag; clr masks hlt so the clock restarts.
    always_comb begin
        bus.t_state = 6'b000000;
        case (state_q)
            S_T1:    bus.t_state = 6'b000001;
            S_T2:    bus.t_state = 6'b000010;
            S_T3:    bus.t_state = 6'b000100;
            S_T4:    bus.t_state = 6'b001000;
            S_T5:    bus.t_state = 6'b010000;
            S_T6:    bus.t_state = 6'b100000;
            default: bus.t_state = 6'b000000;
        endcase
        bus.hlt = (state_q == S_HALT) && !clr;
    end

    // Control word decode from phase and opcode; everything inactive under clr.
    always_comb begin
        bus.cp   = 1'b0;
        bus.ep   = 1'b0;
        bus.lm_n = 1'b1;
        bus.ce_n = 1'b1;
        bus.li_n = 1'b1;
        bus.ei_n = 1'b1;
        bus.la_n = 1'b1;
        bus.ea   = 1'b0;
        bus.su   = 1'b0;
        bus.eu   = 1'b0;
        bus.lb_n = 1'b1;
        bus.lo_n = 1'b1;
        if (!clr) begin
            case (state_q)
                S_T1: begin
                    bus.ep   = 1'b1;
                    bus.lm_n = 1'b0;
                end
                S_T2: begin
                    bus.cp = 1'b1;
                end
                S_T3: begin
                    bus.ce_n = 1'b0;
                    bus.li_n = 1'b0;
                end
                S_T4: begin
                    if (bus.opcode == OP_LDA || bus.opcode == OP_ADD ||
                        bus.opcode == OP_SUB) begin
                        bus.ei_n = 1'b0;
                        bus.lm_n = 1'b0;
                    end else if (bus.opcode == OP_OUT) begin
                        bus.ea   = 1'b1;
                        bus.lo_n = 1'b0;
                    end
                end
                S_T5: begin
                    if (bus.opcode == OP_LDA) begin
                        bus.ce_n = 1'b0;
                        bus.la_n = 1'b0;
                    end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        bus.ce_n = 1'b0;
                        bus.lb_n = 1'b0;
                        bus.su   = (bus.opcode == OP_SUB);
                    end
                end
                S_T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        bus.eu   = 1'b1;
                        bus.la_n = 1'b0;
                        bus.su   = (bus.opcode == OP_SUB);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
